// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch responder.
package fetch_pkg;

    // Responder FSM states: no fetch, counting wait states, word presented
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Word driven whenever no valid instruction is presented
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Wait-state counter width, covers 0..15
    localparam int unsigned WAIT_CNT_W = 4;

    // Byte address to word index; caller truncates to the array index width,
    // which makes the address wrap modulo the array size
    function automatic logic [31:0] word_index(input logic [31:0] pc);
        return pc >> 2;
    endfunction

endpackage

// File: rtl/instr_fetch_resp_if.sv
// Fetch request / IF-ID response / array load bundle.
// Carries fetch_misalign when FETCH_MISALIGN_CHECK_EN is defined.
interface instr_fetch_resp_if #(
    parameter int unsigned BITS      = 32,
    parameter int unsigned MEM_WORDS = 256
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic            req;
    logic [BITS-1:0] pc_addr;
    logic            req_ready;
    logic            flush;
    logic            load_instr;
    logic [BITS-1:0] mem_data;
    logic            instr_valid;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [BITS-1:0] wr_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            fetch_misalign;

    modport master (
        output req, pc_addr, flush, load_instr, wr_en, wr_addr, wr_data,
        input  req_ready, mem_data, instr_valid, fetch_misalign
    );

    modport slave (
        input  req, pc_addr, flush, load_instr, wr_en, wr_addr, wr_data,
        output req_ready, mem_data, instr_valid, fetch_misalign
    );
`else
    modport master (
        output req, pc_addr, flush, load_instr, wr_en, wr_addr, wr_data,
        input  req_ready, mem_data, instr_valid
    );

    modport slave (
        input  req, pc_addr, flush, load_instr, wr_en, wr_addr, wr_data,
        output req_ready, mem_data, instr_valid
    );
`endif

endinterface

// File: rtl/instr_mem_array.sv
// Synchronous one-write / one-read word array, read-before-write on a
// same-index collision. The read register can also be loaded with CLR_WORD.
module instr_mem_array #(
    parameter int unsigned     BITS      = 32,
    parameter int unsigned     MEM_WORDS = 256,
    parameter logic [BITS-1:0] CLR_WORD  = '0
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_WORDS)-1:0] wr_addr,
    input  logic [BITS-1:0]              wr_data,
    input  logic                         rd_en,
    input  logic                         rd_clr,
    input  logic [$clog2(MEM_WORDS)-1:0] rd_addr,
    output logic [BITS-1:0]              rd_data
);

    logic [BITS-1:0] mem [MEM_WORDS];

    // Array write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; clear wins over read
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= CLR_WORD;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction-memory responder at the IF/ID boundary: accepts PC requests,
// returns the word after WAIT_CYCLES wait states, holds it until loaded,
// drops in-flight fetches on flush.
// Optional: FETCH_MISALIGN_CHECK_EN adds fetch_misalign and NOPs misaligned PCs.
module instr_fetch_resp
    import fetch_pkg::*;
#(
    parameter int unsigned BITS        = 32,
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned ADDR_LEFT   = $clog2(MEM_WORDS) - 1,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic                clk,
    input logic                rst_,
    instr_fetch_resp_if.slave  bus
);

    localparam int unsigned           AW      = ADDR_LEFT + 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [BITS-1:0]       NOP_W   = BITS'(NOP_WORD);

    fetch_state_t          state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  pend_q, pend_d;

    logic                  ready_c;
    logic                  accept_c;
    logic [AW-1:0]         new_idx_c;
    logic                  new_mis_c;
    logic                  rd_en_c;
    logic                  rd_clr_c;
    logic [AW-1:0]         rd_addr_c;
    logic [BITS-1:0]       rd_data;

    assign new_idx_c = AW'(word_index(32'(bus.pc_addr)));

`ifdef FETCH_MISALIGN_CHECK_EN
    assign new_mis_c = |bus.pc_addr[1:0];
`else
    assign new_mis_c = 1'b0;
`endif

    // Next-state, counter, array read control and request handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        pend_d    = pend_q;
        rd_en_c   = 1'b0;
        rd_clr_c  = !rst_;
        rd_addr_c = idx_q;

        ready_c  = rst_ && !bus.flush &&
                   ((state_q == IDLE) || ((state_q == HOLD) && bus.load_instr));
        accept_c = bus.req && ready_c;

        if (bus.flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            valid_d  = 1'b0;
            pend_d   = 1'b0;
            rd_clr_c = 1'b1;
        end else begin
            if ((state_q == HOLD) && bus.load_instr) begin
                state_d  = IDLE;
                valid_d  = 1'b0;
                pend_d   = 1'b0;
                rd_clr_c = 1'b1;
            end else if (state_q == WAIT) begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - WAIT_CNT_W'(1);
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    state_d  = HOLD;
                    valid_d  = 1'b1;
                    rd_en_c  = !pend_q;
                    rd_clr_c = rd_clr_c || pend_q;
                end
            end

            if (accept_c) begin
                idx_d  = new_idx_c;
                pend_d = new_mis_c;
                if (WAIT_CYCLES == 0) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    rd_addr_c = new_idx_c;
                    rd_en_c   = !new_mis_c;
                    rd_clr_c  = new_mis_c;
                end else begin
                    state_d  = WAIT;
                    cnt_d    = WAIT_LD;
                    valid_d  = 1'b0;
                    rd_en_c  = 1'b0;
                    rd_clr_c = 1'b1;
                end
            end
        end
    end

    // FSM and fetch bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    instr_mem_array #(
        .BITS      (BITS),
        .MEM_WORDS (MEM_WORDS),
        .CLR_WORD  (NOP_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en_c),
        .rd_clr  (rd_clr_c),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );

    assign bus.req_ready   = ready_c;
    assign bus.mem_data    = rd_data;
    assign bus.instr_valid = valid_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q;

    // Misalign flag accompanies the presented word
    always_ff @(posedge clk) begin
        if (!rst_) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= valid_d && pend_d;
        end
    end

    assign bus.fetch_misalign = mis_q;
`endif

endmodule

// File: tb/tb_instr_fetch_resp.sv
// Bench for instr_fetch_resp: one instance with one wait state, one with none,
// driven by identical stimulus. Honours FETCH_MISALIGN_CHECK_EN.
module tb_instr_fetch_resp;
    import fetch_pkg::*;

    localparam int unsigned BITS      = 32;
    localparam int unsigned MEM_WORDS = 256;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    logic        req, flush, load, wr_en;
    logic [31:0] pc, wr_data;
    logic [7:0]  wr_addr;

    instr_fetch_resp_if #(.BITS(BITS), .MEM_WORDS(MEM_WORDS)) b1 ();
    instr_fetch_resp_if #(.BITS(BITS), .MEM_WORDS(MEM_WORDS)) b0 ();

    assign b1.req = req;      assign b0.req = req;
    assign b1.pc_addr = pc;   assign b0.pc_addr = pc;
    assign b1.flush = flush;  assign b0.flush = flush;
    assign b1.load_instr = load; assign b0.load_instr = load;
    assign b1.wr_en = wr_en;  assign b0.wr_en = wr_en;
    assign b1.wr_addr = wr_addr; assign b0.wr_addr = wr_addr;
    assign b1.wr_data = wr_data; assign b0.wr_data = wr_data;

    instr_fetch_resp #(.BITS(BITS), .MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(1)) dut1 (
        .clk (clk), .rst_ (rst_), .bus (b1)
    );
    instr_fetch_resp #(.BITS(BITS), .MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(0)) dut0 (
        .clk (clk), .rst_ (rst_), .bus (b0)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [MEM_WORDS];

    // Reference model: one pending fetch per instance, valid from a known cycle
    int          wcyc   [2] = '{0, 1};
    bit          m_pend [2];
    int          m_vcyc [2];
    logic [7:0]  m_idx  [2];
    logic [31:0] m_word [2];
    bit          m_mis  [2];

    function automatic logic get_valid(input int d);
        return (d == 1) ? b1.instr_valid : b0.instr_valid;
    endfunction
    function automatic logic [31:0] get_data(input int d);
        return (d == 1) ? b1.mem_data : b0.mem_data;
    endfunction
    function automatic logic get_ready(input int d);
        return (d == 1) ? b1.req_ready : b0.req_ready;
    endfunction
`ifdef FETCH_MISALIGN_CHECK_EN
    function automatic logic get_mis(input int d);
        return (d == 1) ? b1.fetch_misalign : b0.fetch_misalign;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic cleanup();
        req = 1'b0; load = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_ = 1'b0; req = 1'b1; flush = 1'b0; load = 1'b0; wr_en = 1'b0;
        pc = 32'h0; wr_addr = 8'h0; wr_data = 32'h0;
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (get_valid(d) !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", d, get_valid(d)); end
            checks++;
            if (get_data(d) !== 32'h0) begin errors++; $display("FAIL reset_data[%0d]: got %h expected 00000000", d, get_data(d)); end
            checks++;
            if (get_ready(d) !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", d, get_ready(d)); end
`ifdef FETCH_MISALIGN_CHECK_EN
            checks++;
            if (get_mis(d) !== 1'b0) begin errors++; $display("FAIL reset_mis[%0d]: got %b expected 0", d, get_mis(d)); end
`endif
        end
        rst_ = 1'b1; req = 1'b0;
        tick();
        checks++;
        if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", b1.req_ready); end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < int'(MEM_WORDS); i++) mem_write(8'(i), $urandom);
    endtask

    task automatic test_basic();
        mem_write(8'd4, 32'h2010_0005);
        req = 1'b1; pc = 32'h10;
        #1;
        checks++;
        if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b expected 1", b1.req_ready); end
        tick();
        req = 1'b0;
        checks++;
        if (b1.instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid: got %b expected 0", b1.instr_valid); end
        tick();
        checks++;
        if (b1.instr_valid !== 1'b1 || b1.mem_data !== 32'h2010_0005) begin
            errors++; $display("FAIL latency_word: got valid=%b data=%h expected 1 20100005", b1.instr_valid, b1.mem_data);
        end
    endtask

    task automatic test_stall();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (b1.instr_valid !== 1'b1 || b1.mem_data !== 32'h2010_0005 || b1.req_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold: got valid=%b data=%h ready=%b expected 1 20100005 0",
                                   b1.instr_valid, b1.mem_data, b1.req_ready);
            end
            tick();
        end
        load = 1'b1;
        #1;
        checks++;
        if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", b1.req_ready); end
        tick();
        load = 1'b0;
        checks++;
        if (b1.instr_valid !== 1'b0 || b1.mem_data !== 32'h0) begin
            errors++; $display("FAIL release: got valid=%b data=%h expected 0 00000000", b1.instr_valid, b1.mem_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};
        cleanup();
        for (int i = 0; i < 3; i++) mem_write(8'(i), exp_w[i]);
        req = 1'b1; load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i * 4);
            #1;
            checks++;
            if (b0.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, b0.req_ready); end
            tick();
            checks++;
            if (b0.instr_valid !== 1'b1 || b0.mem_data !== exp_w[i]) begin
                errors++; $display("FAIL b2b_word[%0d]: got valid=%b data=%h expected 1 %h", i, b0.instr_valid, b0.mem_data, exp_w[i]);
            end
        end
        req = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (b0.instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", b0.instr_valid); end
        cleanup();
    endtask

    task automatic test_flush();
        req = 1'b1; pc = 32'h14;
        tick();
        flush = 1'b1;
        #1;
        checks++;
        if (b1.req_ready !== 1'b0 || b0.req_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b/%b expected 0/0", b1.req_ready, b0.req_ready);
        end
        tick();
        flush = 1'b0; req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b1.instr_valid !== 1'b0 || b1.mem_data !== 32'h0 || b0.instr_valid !== 1'b0) begin
                errors++; $display("FAIL flush_kill[%0d]: got valid=%b data=%h v0=%b expected 0 00000000 0",
                                   i, b1.instr_valid, b1.mem_data, b0.instr_valid);
            end
            tick();
        end
        checks++;
        if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: got %b expected 1", b1.req_ready); end
    endtask

    task automatic test_wrap();
        mem_write(8'd0, 32'hC0DE_0400);
        req = 1'b1; pc = 32'h400;
        tick();
        req = 1'b0;
        tick();
        checks++;
        if (b1.instr_valid !== 1'b1 || b1.mem_data !== 32'hC0DE_0400) begin
            errors++; $display("FAIL wrap_word: got valid=%b data=%h expected 1 c0de0400", b1.instr_valid, b1.mem_data);
        end
        load = 1'b1; tick(); load = 1'b0;
    endtask

    task automatic test_rbw();
        mem_write(8'd7, 32'hAAAA_0007);
        req = 1'b1; pc = 32'h1C;
        tick();
        req = 1'b0;
        wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'hBBBB_0007;
        tick();
        wr_en = 1'b0; ref_mem[7] = 32'hBBBB_0007;
        checks++;
        if (b1.mem_data !== 32'hAAAA_0007) begin errors++; $display("FAIL rbw_old: got %h expected aaaa0007", b1.mem_data); end
        load = 1'b1; tick(); load = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        checks++;
        if (b1.instr_valid !== 1'b1 || b1.mem_data !== 32'hBBBB_0007) begin
            errors++; $display("FAIL rbw_new: got valid=%b data=%h expected 1 bbbb0007", b1.instr_valid, b1.mem_data);
        end
        load = 1'b1; tick(); load = 1'b0;
    endtask

`ifdef FETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        cleanup();
        req = 1'b1; pc = 32'h12;
        tick();
        req = 1'b0;
        checks++;
        if (b1.fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_wait: got %b expected 0", b1.fetch_misalign); end
        tick();
        checks++;
        if (b1.instr_valid !== 1'b1 || b1.mem_data !== 32'h0 || b1.fetch_misalign !== 1'b1) begin
            errors++; $display("FAIL mis_word: got valid=%b data=%h mis=%b expected 1 00000000 1",
                               b1.instr_valid, b1.mem_data, b1.fetch_misalign);
        end
        load = 1'b1; tick(); load = 1'b0;
        checks++;
        if (b1.fetch_misalign !== 1'b0 || b1.instr_valid !== 1'b0) begin
            errors++; $display("FAIL mis_clear: got mis=%b valid=%b expected 0 0", b1.fetch_misalign, b1.instr_valid);
        end
        req = 1'b1; pc = 32'h10;
        tick();
        req = 1'b0;
        tick();
        checks++;
        if (b1.fetch_misalign !== 1'b0 || b1.mem_data !== 32'h2010_0005) begin
            errors++; $display("FAIL mis_aligned: got mis=%b data=%h expected 0 20100005", b1.fetch_misalign, b1.mem_data);
        end
        load = 1'b1; tick(); load = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        cleanup();
        req = 1'b1; pc = 32'h10;
        tick();
        req = 1'b0; rst_ = 1'b0;
        tick();
        checks++;
        if (b1.instr_valid !== 1'b0 || b1.mem_data !== 32'h0 || b1.req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got valid=%b data=%h ready=%b expected 0 00000000 0",
                               b1.instr_valid, b1.mem_data, b1.req_ready);
        end
        rst_ = 1'b1;
        tick();
        checks++;
        if (b1.instr_valid !== 1'b0 || b1.req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_after: got valid=%b ready=%b expected 0 1", b1.instr_valid, b1.req_ready);
        end
    endtask

    task automatic test_random(input int n);
        int  cyc;
        bit  exp_v [2];
        bit  exp_r;
        bit  acc;
        cleanup();
        for (int d = 0; d < 2; d++) m_pend[d] = 1'b0;
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            for (int d = 0; d < 2; d++) begin
                exp_v[d] = m_pend[d] && (cyc >= m_vcyc[d]);
                checks++;
                if (get_valid(d) !== exp_v[d] || get_data(d) !== (exp_v[d] ? m_word[d] : 32'h0)) begin
                    errors++; $display("FAIL rand_out[%0d] cyc %0d: got valid=%b data=%h expected %b %h",
                                       d, cyc, get_valid(d), get_data(d), exp_v[d], exp_v[d] ? m_word[d] : 32'h0);
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                checks++;
                if (get_mis(d) !== (exp_v[d] && m_mis[d])) begin
                    errors++; $display("FAIL rand_mis[%0d] cyc %0d: got %b expected %b", d, cyc, get_mis(d), exp_v[d] && m_mis[d]);
                end
`endif
            end
            flush   = ($urandom_range(0, 9) == 0);
            req     = ($urandom_range(0, 9) < 6);
            load    = ($urandom_range(0, 1) == 1);
            pc      = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            wr_en   = ($urandom_range(0, 9) < 3);
            wr_addr = 8'($urandom);
            wr_data = $urandom;
            #1;
            for (int d = 0; d < 2; d++) begin
                exp_r = !flush && (!m_pend[d] || (exp_v[d] && load));
                checks++;
                if (get_ready(d) !== exp_r) begin
                    errors++; $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", d, cyc, get_ready(d), exp_r);
                end
                acc = req && exp_r;
                if (flush || (exp_v[d] && load)) m_pend[d] = 1'b0;
                if (acc) begin
                    m_pend[d] = 1'b1;
                    m_vcyc[d] = cyc + 1 + wcyc[d];
                    m_idx[d]  = pc[9:2];
`ifdef FETCH_MISALIGN_CHECK_EN
                    m_mis[d]  = (pc[1:0] != 2'b00);
`else
                    m_mis[d]  = 1'b0;
`endif
                end
                if (m_pend[d] && m_vcyc[d] == cyc + 1)
                    m_word[d] = m_mis[d] ? 32'h0 : ref_mem[m_idx[d]];
            end
            if (wr_en) ref_mem[wr_addr] = wr_data;
            cyc++;
            tick();
        end
        wr_en = 1'b0;
        cleanup();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        fill_mem();
        test_basic();
        test_stall();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_rbw();
`ifdef FETCH_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_reset_mid();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_resp.md
Name: instr_fetch_resp

Overview:
Instruction-memory responder on the fetch side of the IF/ID boundary. It accepts PC fetch requests from the fetch stage and returns instruction words to the IF/ID pipeline register after a fixed number of wait states. It holds a returned word until the decode side loads it, and drops in-flight fetches on a branch/jump flush. The word array is internal and is written through a load port, used by the boot loader and the bench.

Parameters:
BITS, 32, instruction/address word width
MEM_WORDS, 256, number of instruction words in the array
ADDR_LEFT, $clog2(MEM_WORDS)-1, left bit of the word index
WAIT_CYCLES, 1, wait states between request accept and data valid (0..15)
NOP_WORD, 32'h0000_0000, word driven when no valid instruction is present

Ports:
clk  input  1  clock, rising edge
rst_  input  1  synchronous active-low reset
req  input  1  fetch request valid
pc_addr  input  BITS  byte address of fetch; word index = pc_addr[ADDR_LEFT+2:2]
req_ready  output  1  request accepted this cycle when req && req_ready
flush  input  1  branch/jump redirect; kill pending fetch
load_instr  input  1  IF/ID register captures mem_data this cycle
mem_data  output  BITS  instruction word to IF/ID
instr_valid  output  1  mem_data holds a valid instruction
wr_en  input  1  array write enable
wr_addr  input  ADDR_LEFT+1  array word index for write
wr_data  input  BITS  array write data

Behaviour:
- Reset (rst_ low at a clk edge): state=IDLE, wait counter=0, latched address=0, mem_data=NOP_WORD, instr_valid=0. req_ready=0 while rst_ is low. Array contents are not reset.
- States:
  - IDLE: no fetch pending.
  - WAIT: counting wait states.
  - HOLD: data valid, waiting for load_instr.
- req_ready = rst_ && !flush && (IDLE || (HOLD && load_instr)). Combinational from state and inputs.
- Accept: latch the word index and load counter=WAIT_CYCLES.
  - If WAIT_CYCLES=0, go directly to HOLD next cycle.
  - Otherwise go to WAIT.
- WAIT: counter decrements each cycle. On the cycle counter==1, go to HOLD next cycle.
- Latency: accept in cycle N -> instr_valid=1 in cycle N+1+WAIT_CYCLES.
- Array read: happens on the edge that enters HOLD, using the latched index. mem_data is registered and stable for the whole of HOLD.
- HOLD, load_instr=1, no new accept: go to IDLE, instr_valid=0, mem_data=NOP_WORD.
- HOLD, load_instr=1, new accept: back-to-back fetch.
  - With WAIT_CYCLES=0, remain in HOLD with the new word.
  - Otherwise go to WAIT with instr_valid=0.
- HOLD, load_instr=0: hold mem_data and instr_valid indefinitely (stall).
- flush=1 in any state: next state IDLE, instr_valid=0, mem_data=NOP_WORD, counter cleared, no accept that cycle. Flush has priority over load_instr and req.
- Write port: wr_en writes wr_data at wr_addr on the edge; it is independent of the fetch FSM.
  - A write and a read to the same index on the same edge return the old data (read-before-write).
- Index arithmetic: pc_addr bits above ADDR_LEFT+2 are ignored, so the address wraps modulo MEM_WORDS.
- rst_ low mid-fetch: fetch abandoned, same as the reset values above.

Optional Feature:
Macro FETCH_MISALIGN_CHECK_EN.
- Defined: adds output fetch_misalign (1 bit, reset 0). An accepted request with pc_addr[1:0]!=0 completes with normal latency but returns NOP_WORD. fetch_misalign=1 is asserted alongside instr_valid for that word. fetch_misalign clears when the word is loaded or flushed.
- Undefined: no port; pc_addr[1:0] are ignored.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, HOLD};
  - NOP_WORD constant;
  - the word-index extraction function.
- One natural sub-module is instr_mem_array: synchronous single-write, single-read array with read-before-write, parameterised by BITS and MEM_WORDS.
- The FSM and counter stay in instr_fetch_resp.

Test Plan:
- Reset, then write 0x2010_0005 at index 4. Request pc_addr=0x10 with WAIT_CYCLES=1 -> req_ready=1 at the accept cycle N; instr_valid=1 with mem_data=0x2010_0005 at N+2.
- Word valid with load_instr=0 for 5 cycles -> mem_data and instr_valid stable, req_ready=0. Then load_instr=1 -> next cycle instr_valid=0, mem_data=0.
- WAIT_CYCLES=0, req held high with pc 0x0,0x4,0x8 and load_instr=1 -> one word valid per cycle, in order, with no bubbles.
- flush=1 during WAIT -> next cycle state IDLE, instr_valid stays 0, no stale word appears later. flush and req in the same cycle -> req_ready=0.
- pc_addr=0x400 with MEM_WORDS=256 -> returns the word at index 0 (wrap). Write index 7 on the same edge the HOLD read of index 7 occurs -> old data returned; a refetch returns the new data.
- With FETCH_MISALIGN_CHECK_EN, pc_addr=0x12 -> mem_data=0, fetch_misalign=1 alongside instr_valid. Drop rst_ low mid-WAIT -> all outputs take their reset values the next cycle.
